// File: rtl/interleave_pkg.sv
// Shared constants for the stream interleaver: index-width helper and the
// bank-state encoding used by assertions and the bench.
package interleave_pkg;

  // Bank lifecycle encoding.
  localparam logic [1:0] EMPTY    = 2'd0;
  localparam logic [1:0] FILLING  = 2'd1;
  localparam logic [1:0] FULL     = 2'd2;
  localparam logic [1:0] DRAINING = 2'd3;

  // Ceiling log2, floored at 1 so index vectors are never zero width.
  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Derive a bank's lifecycle state from its full flag and whether the
  // pointer currently owning it has moved past index 0.
  function automatic logic [1:0] bank_state(input logic is_full, input logic idx_nz);
    if (is_full) return idx_nz ? DRAINING : FULL;
    else         return idx_nz ? FILLING : EMPTY;
  endfunction

endpackage

// File: rtl/interleave_map.sv
// Combinational G-bit group transpose: output word k takes group k of every
// stored word j and places it in group slot j.
module interleave_map
  import interleave_pkg::*;
#(
  parameter int NWORDS = 4,
  parameter int GROUP  = 2,
  parameter int WIDTH  = NWORDS * GROUP,
  parameter int IW     = clog2(NWORDS)
) (
  input  logic [NWORDS-1:0][WIDTH-1:0] words,
  input  logic [IW-1:0]                k,
  output logic [WIDTH-1:0]             word
);

  // One group slot per source word.
  for (genvar j = 0; j < NWORDS; j++) begin : g_grp
    assign word[GROUP*j +: GROUP] = words[j][GROUP*k +: GROUP];
  end

endmodule

// File: rtl/stream_interleaver.sv
// Ping-pong block interleaver: fills one bank of NWORDS words while the
// other drains through the group transpose, one word per clock.
// Optional feature macro: STREAM_INTERLEAVER_BYPASS_EN adds a per-block
// bypass input captured on word 0 of each block.
module stream_interleaver
  import interleave_pkg::*;
#(
  parameter int NWORDS = 4,
  parameter int GROUP  = 2,
  parameter int WIDTH  = NWORDS * GROUP
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [15:0]      blocks_done
`ifdef STREAM_INTERLEAVER_BYPASS_EN
  ,
  input  logic             bypass
`endif
);

  localparam int IW = clog2(NWORDS);
  localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

  if (WIDTH != NWORDS * GROUP) begin : g_bad_width
    $error("stream_interleaver: WIDTH must equal NWORDS*GROUP");
  end
  if (NWORDS < 2 || (NWORDS & (NWORDS - 1)) != 0) begin : g_bad_nwords
    $error("stream_interleaver: NWORDS must be a power of two >= 2");
  end

  logic [1:0][NWORDS-1:0][WIDTH-1:0] bank;
  logic                              wbank, rbank;
  logic [IW-1:0]                     win, rout;
  logic [1:0]                        full;
  logic [1:0][1:0]                   bank_st;
  logic                              acc, drn;
  logic [WIDTH-1:0]                  mapped;

  assign in_ready  = !full[wbank];
  assign out_valid = full[rbank];
  assign out_last  = (rout == LAST);
  assign acc       = in_valid && in_ready;
  assign drn       = out_valid && out_ready;

  // Bank payload; intentionally not reset, the full flags gate visibility.
  always_ff @(posedge clock) begin
    if (acc) bank[wbank][win] <= in_data;
  end

  // Write/read pointers, full flags and drained-block counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      wbank       <= 1'b0;
      rbank       <= 1'b0;
      win         <= '0;
      rout        <= '0;
      full        <= 2'b00;
      blocks_done <= 16'd0;
    end else begin
      if (acc) begin
        if (win == LAST) begin
          full[wbank] <= 1'b1;
          wbank       <= ~wbank;
          win         <= '0;
        end else begin
          win <= win + IW'(1);
        end
      end
      if (drn) begin
        if (rout == LAST) begin
          full[rbank] <= 1'b0;
          rbank       <= ~rbank;
          rout        <= '0;
          blocks_done <= blocks_done + 16'd1;
        end else begin
          rout <= rout + IW'(1);
        end
      end
    end
  end

  interleave_map #(.NWORDS(NWORDS), .GROUP(GROUP), .WIDTH(WIDTH), .IW(IW)) u_map (
    .words (bank[rbank]),
    .k     (rout),
    .word  (mapped)
  );

`ifdef STREAM_INTERLEAVER_BYPASS_EN
  logic [1:0] byp;

  // Bypass flag latched per bank when the block's first word lands.
  always_ff @(posedge clock) begin
    if (acc && win == '0) byp[wbank] <= bypass;
  end

  assign out_data = byp[rbank] ? bank[rbank][rout] : mapped;
`else
  assign out_data = mapped;
`endif

  // Per-bank lifecycle view derived from the pointers that own each bank.
  for (genvar b = 0; b < 2; b++) begin : g_st
    assign bank_st[b] = bank_state(full[b],
                          full[b] ? (rbank == 1'(b) && rout != '0)
                                  : (wbank == 1'(b) && win != '0));
  end

  a_wr_bank: assert property (@(posedge clock) disable iff (reset)
    acc |-> (bank_st[wbank] == EMPTY || bank_st[wbank] == FILLING));
  a_rd_bank: assert property (@(posedge clock) disable iff (reset)
    drn |-> (bank_st[rbank] == FULL || bank_st[rbank] == DRAINING));

endmodule
